// File: rtl/bus_master_fsm.sv
// Initiator-side controller for the 32-bit handshaked peripheral bus.
// Runs one command/data(/status) exchange with a single subsystem per start.
module bus_master_fsm #(
    parameter int NUM_SUBSYSTEMS = 8,
    parameter int STATUS_RETURN  = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int SEL_W = (NUM_SUBSYSTEMS > 1) ? $clog2(NUM_SUBSYSTEMS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               cmd_word,
    input  logic                      cmd_rw,
    input  logic [SEL_W-1:0]          subsystem_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [31:0]               data_word,
    output logic [31:0]               status_word,
    output logic [31:0]               bus_out,
    output logic                      bus_oe,
    input  logic [31:0]               bus_in,
    output logic                      RW,
    output logic [NUM_SUBSYSTEMS-1:0] subsystem_enable,
    output logic                      handshake_1,
    input  logic                      handshake_2
);

    localparam int TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [3:0] {
        S_IDLE, S_ENABLE, S_CMD_STB, S_CMD_REL,
        S_DAT_WAIT, S_DAT_ACK, S_DAT_REL,
        S_STS_WAIT, S_STS_ACK, S_STS_REL,
        S_FINISH, S_ABORT
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [31:0]       cmd_q, cmd_d;
    logic              rw_q, rw_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       stat_q, stat_d;
    logic              h2;
    logic              tmo;
    logic [NUM_SUBSYSTEMS-1:0] en_sel;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign h2 = handshake_2;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= handshake_2;
                    for (int i = 1; i < SYNC_STAGES; i++)
                        sync_q[i] <= sync_q[i-1];
                end
            end
            assign h2 = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            rw_q    <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            rw_q    <= rw_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            stat_q  <= stat_d;
        end
    end

    // Wait-condition checks come first so a same-cycle timeout loses.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rw_d    = rw_q;
        sel_d   = sel_q;
        data_d  = data_q;
        stat_d  = stat_q;
        tmo     = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_W'(TO_LIM));
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d = S_ENABLE;
                cmd_d   = cmd_word;
                rw_d    = cmd_rw;
                sel_d   = subsystem_sel;
            end
            S_ENABLE:   state_d = S_CMD_STB;
            S_CMD_STB:  if (h2) state_d = S_CMD_REL;
                        else if (tmo) state_d = S_ABORT;
            S_CMD_REL:  if (!h2) state_d = S_DAT_WAIT;
                        else if (tmo) state_d = S_ABORT;
            S_DAT_WAIT: if (h2) begin
                            state_d = S_DAT_ACK;
                            data_d  = bus_in;
                        end else if (tmo) state_d = S_ABORT;
            S_DAT_ACK:  if (!h2) state_d = S_DAT_REL;
                        else if (tmo) state_d = S_ABORT;
            S_DAT_REL:  state_d = (STATUS_RETURN != 0) ? S_STS_WAIT : S_FINISH;
            S_STS_WAIT: if (h2) begin
                            state_d = S_STS_ACK;
                            stat_d  = bus_in;
                        end else if (tmo) state_d = S_ABORT;
            S_STS_ACK:  if (!h2) state_d = S_STS_REL;
                        else if (tmo) state_d = S_ABORT;
            S_STS_REL:  state_d = S_FINISH;
            S_FINISH:   state_d = S_IDLE;
            S_ABORT:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (state_d != state_q)
            cnt_d = '0;
        else if (TIMEOUT_CYCLES != 0 && !tmo)
            cnt_d = cnt_q + TO_W'(1);
        else
            cnt_d = cnt_q;
    end

    always_comb begin
        en_sel = '0;
        for (int i = 0; i < NUM_SUBSYSTEMS; i++)
            en_sel[i] = (sel_q == SEL_W'(i));
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH) || (state_q == S_ABORT);
    assign error       = (state_q == S_ABORT);
    assign bus_oe      = (state_q == S_ENABLE) || (state_q == S_CMD_STB);
    assign bus_out     = bus_oe ? cmd_q : 32'h0;
    assign handshake_1 = state_q inside {S_CMD_STB, S_DAT_ACK, S_STS_ACK};
    assign RW          = busy & rw_q;
    assign data_word   = data_q;
    assign status_word = stat_q;

    // Out-of-range selects match no bit, so no subsystem is enabled.
    assign subsystem_enable =
        (state_q inside {S_ENABLE, S_CMD_STB, S_CMD_REL, S_DAT_WAIT, S_DAT_ACK,
                         S_DAT_REL, S_STS_WAIT, S_STS_ACK, S_STS_REL})
        ? en_sel : '0;

endmodule

// File: tb/tb_bus_master_fsm.sv
// Bench for bus_master_fsm: two builds driven by a subsystem model
// with random handshake delays, checked against a transaction scoreboard.
`timescale 1ns/1ps
module tb_bus_master_fsm;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start       [2];
    logic [31:0] cmd_word    [2];
    logic        cmd_rw      [2];
    logic [2:0]  sel_i       [2];
    logic        busy        [2];
    logic        done        [2];
    logic        error       [2];
    logic [31:0] data_word   [2];
    logic [31:0] status_word [2];
    logic [31:0] bus_out     [2];
    logic        bus_oe      [2];
    logic [31:0] bus_in      [2];
    logic        rw_o        [2];
    logic        hs1         [2];
    logic        hs2         [2];
    logic        drv         [2];
    logic [31:0] drv_val     [2];
    logic [7:0]  en0;
    logic [4:0]  en1;

    logic [31:0] exp_data [2];
    logic [31:0] exp_stat [2];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign bus_in[0] = drv[0] ? drv_val[0] : 32'h0;
    assign bus_in[1] = drv[1] ? drv_val[1] : 32'h0;

    bus_master_fsm #(
        .NUM_SUBSYSTEMS(8), .STATUS_RETURN(1),
        .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)
    ) u_dut0 (
        .clk(clk), .reset(rst_n), .start(start[0]),
        .cmd_word(cmd_word[0]), .cmd_rw(cmd_rw[0]),
        .subsystem_sel(sel_i[0]), .busy(busy[0]), .done(done[0]),
        .error(error[0]), .data_word(data_word[0]),
        .status_word(status_word[0]), .bus_out(bus_out[0]),
        .bus_oe(bus_oe[0]), .bus_in(bus_in[0]), .RW(rw_o[0]),
        .subsystem_enable(en0), .handshake_1(hs1[0]),
        .handshake_2(hs2[0])
    );

    bus_master_fsm #(
        .NUM_SUBSYSTEMS(5), .STATUS_RETURN(0),
        .SYNC_STAGES(0), .TIMEOUT_CYCLES(TMO)
    ) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start[1]),
        .cmd_word(cmd_word[1]), .cmd_rw(cmd_rw[1]),
        .subsystem_sel(sel_i[1]), .busy(busy[1]), .done(done[1]),
        .error(error[1]), .data_word(data_word[1]),
        .status_word(status_word[1]), .bus_out(bus_out[1]),
        .bus_oe(bus_oe[1]), .bus_in(bus_in[1]), .RW(rw_o[1]),
        .subsystem_enable(en1), .handshake_1(hs1[1]),
        .handshake_2(hs2[1])
    );

    function automatic int num_of(input int k);
        return (k == 0) ? 8 : 5;
    endfunction

    function automatic bit sr_of(input int k);
        return (k == 0);
    endfunction

    function automatic logic [7:0] en_of(input int k);
        return (k == 0) ? en0 : {3'b000, en1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input int k, input string tag);
        chk({tag, "_ctl"}, {busy[k], done[k], error[k], bus_oe[k],
                            rw_o[k], hs1[k]}, 0);
        chk({tag, "_en"}, en_of(k), 0);
        chk({tag, "_bus"}, bus_out[k], 0);
        chk({tag, "_words"}, {data_word[k], status_word[k]},
            {exp_data[k], exp_stat[k]});
    endtask

    // One host transaction plus the addressed subsystem's responses.
    task automatic run_txn(input int k, input logic [31:0] cmd,
                           input bit rw, input int sel,
                           input logic [31:0] dv, input logic [31:0] sv,
                           input int dly, input bit mute,
                           input bit restart, input bit rst_ack);
        int phase = 0, cnt = 0, cyc;
        int first_rise = -1, last_fall = -1, done_cyc = -1;
        int n_done = 0, bad_oe = 0, bad_en = 0, bad_rw = 0;
        int ovl = 0, en_hits = 0, extra = 0;
        bit armed = 0, prev_h1 = 0, err_seen = 0, rst_done = 0;
        bit cond, exp_err;
        logic [7:0]  exp_en;
        logic [31:0] cmd_seen = 32'h0;

        exp_en  = (sel < num_of(k)) ? 8'(1 << sel) : 8'h0;
        exp_err = mute || (sel >= num_of(k));

        @(negedge clk);
        start[k] = 1'b1;
        cmd_word[k] = cmd;
        cmd_rw[k] = rw;
        sel_i[k] = 3'(sel);
        @(negedge clk);
        start[k] = 1'b0;
        chk("busy_after_start", busy[k], 1);

        for (cyc = 0; cyc < 300 && n_done == 0 && !rst_done; cyc++) begin
            cmd_word[k] = $urandom;
            cmd_rw[k]   = 1'($urandom_range(0, 1));
            sel_i[k]    = 3'($urandom_range(0, 7));
            start[k]    = restart && (cyc == 3);

            if (bus_oe[k] && bus_out[k] !== cmd) bad_oe++;
            if (bus_oe[k] && drv[k]) ovl++;
            if (en_of(k) != 0 && en_of(k) != exp_en) bad_en++;
            if (en_of(k) == exp_en && exp_en != 0) en_hits++;
            if (rw_o[k] !== rw) bad_rw++;
            if (hs1[k] && !prev_h1 && first_rise < 0) first_rise = cyc;
            if (!hs1[k] && prev_h1) last_fall = cyc;
            prev_h1 = hs1[k];
            if (done[k]) begin
                n_done++;
                done_cyc = cyc;
                err_seen = error[k];
                chk("quiet_at_done", {hs1[k], bus_oe[k], |en_of(k)}, 0);
            end

            if (rst_ack && phase == 3 && hs1[k]) begin
                #2 rst_n = 1'b0;
                #1;
                exp_data[0] = 0; exp_stat[0] = 0;
                exp_data[1] = 0; exp_stat[1] = 0;
                chk_idle(k, "async_rst");
                hs2[k] = 1'b0;
                drv[k] = 1'b0;
                rst_done = 1;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                case (phase)
                    0: cond = ((en_of(k) & exp_en) != 0) && hs1[k];
                    1, 4, 7: cond = !hs1[k];
                    2, 5: cond = 1'b1;
                    3, 6: cond = hs1[k];
                    default: cond = 1'b0;
                endcase
                if (mute) cond = 1'b0;
                if (!armed && cond) begin
                    armed = 1;
                    cnt = dly;
                end
                if (armed) begin
                    if (cnt == 0) begin
                        armed = 0;
                        case (phase)
                            0: begin cmd_seen = bus_out[k]; hs2[k] = 1'b1; end
                            1: hs2[k] = 1'b0;
                            2: begin drv_val[k] = dv; drv[k] = 1'b1; hs2[k] = 1'b1; end
                            5: begin drv_val[k] = sv; drv[k] = 1'b1; hs2[k] = 1'b1; end
                            3, 6: begin drv[k] = 1'b0; hs2[k] = 1'b0; end
                            default: ;
                        endcase
                        phase = (phase == 4 && !sr_of(k)) ? 8 : phase + 1;
                    end else begin
                        cnt--;
                    end
                end
                @(negedge clk);
            end
        end
        start[k] = 1'b0;
        if (rst_done) return;

        hs2[k] = 1'b0;
        drv[k] = 1'b0;
        repeat (4) begin
            if (done[k] || busy[k]) extra++;
            @(negedge clk);
        end

        if (!exp_err) begin
            exp_data[k] = dv;
            if (sr_of(k)) exp_stat[k] = sv;
        end
        chk("done_count", n_done, 1);
        chk("trailing_activity", extra, 0);
        chk("error_flag", err_seen, exp_err);
        if (exp_err)
            chk("timeout_latency", done_cyc - first_rise, TMO);
        else
            chk("finish_latency", done_cyc - last_fall, 1);
        chk("data_word", data_word[k], exp_data[k]);
        chk("status_word", status_word[k], exp_stat[k]);
        chk("cmd_on_bus", cmd_seen, exp_err ? 32'h0 : cmd);
        chk("bus_out_value", bad_oe, 0);
        chk("oe_overlap", ovl, 0);
        chk("wrong_enable", bad_en, 0);
        chk("enable_seen", en_hits > 0, exp_en != 0);
        chk("rw_held", bad_rw, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 0; cmd_word[k] = 0; cmd_rw[k] = 0; sel_i[k] = 0;
            hs2[k] = 0; drv[k] = 0; drv_val[k] = 0;
            exp_data[k] = 0; exp_stat[k] = 0;
        end
        repeat (3) @(negedge clk);
        chk_idle(0, "reset0");
        chk_idle(1, "reset1");
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(0, 32'h12345678, 1, 3, 32'hCAFEF00D, 32'h1, 2, 0, 0, 0);
        run_txn(1, 32'h0BADBEEF, 0, 2, 32'hA5A5A5A5, 32'h5A5A5A5A, 2, 0, 0, 0);
        run_txn(0, 32'h0F0F0F0F, 0, 6, 32'h11111111, 32'h2, 3, 1, 0, 0);
        run_txn(0, 32'h76543210, 1, 1, 32'h33333333, 32'h4, 3, 0, 1, 0);
        run_txn(0, 32'hDEADBEEF, 1, 5, 32'h44444444, 32'h5, 4, 0, 0, 1);
        run_txn(0, 32'h00000001, 0, 0, 32'h55555555, 32'h6, 2, 0, 0, 0);
        run_txn(0, 32'h89ABCDEF, 1, 7, 32'h66666666, 32'h7, 7, 0, 0, 0);
        run_txn(1, 32'h13579BDF, 1, 4, 32'h77777777, 32'h8, 7, 0, 0, 0);
        run_txn(1, 32'h2468ACE0, 0, 6, 32'h88888888, 32'h9, 2, 0, 0, 0);

        for (int t = 0; t < 20; t++) begin
            int k;
            k = $urandom_range(0, 1);
            run_txn(k, $urandom, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), $urandom, $urandom,
                    $urandom_range(1, 7), $urandom_range(0, 7) == 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
